// File: rtl/video_pkg.sv
// video_pkg: sequencer state encoding and frame geometry shared with the image source
package video_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_KICK, ST_WAIT_VS, ST_ACTIVE, ST_GAP} state_t;
  localparam int VID_WIDTH = 768;
  localparam int VID_HEIGHT = 512;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: registers N source strobes and flags rising/falling edges on the registered copy
// Ports: HCLK/HRESETn clock and async active-low reset; d raw inputs; q registered copy;
//   rise/fall one-cycle edge strobes derived from q and its delayed copy
module sync_edge_det #(
  parameter int N = 3
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic [N-1:0] d,
  output logic [N-1:0] q,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall
);
  logic [N-1:0] q_d;
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      q   <= '0;
      q_d <= '0;
    end else begin
      q   <= d;
      q_d <= q;
    end
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: kicks the image source per frame, counts pixels/lines, gaps frames, flags errors
// Ports: HCLK/HRESETn clock and async active-low reset; run_i continuous mode, single_i one frame,
//   abort_i immediate stop; src_resetn_o source reset; src_vsync_i/src_hsync_i/src_de_i source timing;
//   busy_o, frame_done_o, frame_cnt_o, line_cnt_o status; err_len_o/err_to_o sticky errors
module frame_sequencer
  import video_pkg::*;
#(
  parameter int WIDTH       = VID_WIDTH,
  parameter int HEIGHT      = VID_HEIGHT,
  parameter int KICK_CYCLES = 4,
  parameter int GAP_CYCLES  = 1000,
  parameter int TIMEOUT     = 4096,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   run_i,
  input  logic                   single_i,
  input  logic                   abort_i,
  output logic                   src_resetn_o,
  input  logic                   src_vsync_i,
  input  logic                   src_hsync_i,
  input  logic                   src_de_i,
  output logic                   busy_o,
  output logic                   frame_done_o,
  output logic [FRAME_CNT_W-1:0] frame_cnt_o,
  output logic [9:0]             line_cnt_o,
  output logic                   err_len_o,
  output logic                   err_to_o
);
  localparam int PW = $clog2(WIDTH + 2) + 1;
  localparam int KW = $clog2(KICK_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t        state;
  logic [KW-1:0] kick_cnt;
  logic [GW-1:0] gap_cnt;
  logic [TW-1:0] wd;
  logic [PW-1:0] pix;
  logic [2:0]    q, rise, fall;
  logic          vs_rise, vs_fall, de_fall, act, unused_hs;
  sync_edge_det #(.N(3)) u_sync (
    .HCLK   (HCLK),
    .HRESETn(HRESETn),
    .d      ({src_vsync_i, src_hsync_i, src_de_i}),
    .q      (q),
    .rise   (rise),
    .fall   (fall)
  );
  assign vs_rise   = rise[2];
  assign vs_fall   = fall[2];
  assign de_fall   = fall[0];
  assign act       = rise[2] | fall[2] | rise[0] | fall[0];
  assign unused_hs = ^{q[2:1], rise[1], fall[1]};
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state        <= ST_IDLE;
      src_resetn_o <= 1'b0;
      busy_o       <= 1'b0;
      frame_done_o <= 1'b0;
      frame_cnt_o  <= '0;
      line_cnt_o   <= '0;
      err_len_o    <= 1'b0;
      err_to_o     <= 1'b0;
      kick_cnt     <= '0;
      gap_cnt      <= '0;
      wd           <= '0;
      pix          <= '0;
    end else begin
      frame_done_o <= 1'b0;
      if (abort_i) begin
        state        <= ST_IDLE;
        src_resetn_o <= 1'b0;
        busy_o       <= 1'b0;
      end else
        case (state)
          ST_IDLE:
            if (run_i || single_i) begin
              state      <= ST_KICK;
              busy_o     <= 1'b1;
              err_len_o  <= 1'b0;
              err_to_o   <= 1'b0;
              kick_cnt   <= '0;
              line_cnt_o <= '0;
              pix        <= '0;
              wd         <= '0;
            end
          ST_KICK: begin
            line_cnt_o <= '0;
            pix        <= '0;
            wd         <= '0;
            kick_cnt   <= kick_cnt + 1'b1;
            if (kick_cnt == KW'(KICK_CYCLES - 1)) begin
              state        <= ST_WAIT_VS;
              src_resetn_o <= 1'b1;
            end
          end
          ST_WAIT_VS, ST_ACTIVE: begin
            wd <= act ? '0 : wd + 1'b1;
            if (!act && wd == TW'(TIMEOUT - 1)) begin
              err_to_o     <= 1'b1;
              src_resetn_o <= 1'b0;
              busy_o       <= 1'b0;
              state        <= ST_IDLE;
            end else if (state == ST_WAIT_VS) begin
              if (vs_fall) state <= ST_ACTIVE;
            end else begin
              // saturate so an overlong line can never alias back to WIDTH
              if (q[0] && pix != '1) pix <= pix + 1'b1;
              if (de_fall) begin
                line_cnt_o <= line_cnt_o + 10'd1;
                pix        <= '0;
                if (pix != PW'(WIDTH)) err_len_o <= 1'b1;
              end
              // a VSYNC rise before the last line means the source restarted: short frame
              if ((de_fall && line_cnt_o == 10'(HEIGHT - 1)) || vs_rise) begin
                state        <= ST_GAP;
                src_resetn_o <= 1'b0;
                gap_cnt      <= '0;
                if (de_fall && line_cnt_o == 10'(HEIGHT - 1)) begin
                  frame_done_o <= 1'b1;
                  frame_cnt_o  <= frame_cnt_o + 1'b1;
                end else
                  err_len_o <= 1'b1;
              end
            end
          end
          ST_GAP: begin
            gap_cnt <= gap_cnt + 1'b1;
            if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
              state    <= run_i ? ST_KICK : ST_IDLE;
              busy_o   <= run_i;
              kick_cnt <= '0;
            end
          end
          default: begin
            state        <= ST_IDLE;
            src_resetn_o <= 1'b0;
            busy_o       <= 1'b0;
          end
        endcase
    end
endmodule
